// File: rtl/autocorrelation_calculator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : autocorrelation_calculator                                      |
// | Purpose  : Autocorrelation of one block of signed samples for lags         |
// |            0..ORDER. Exact fixed-point MAC per lag, conversion to IEEE-754 |
// |            single precision when the results are drained.                  |
// | Ports    : iClock/iReset (async, active high), iEnable (global hold),      |
// |            iValid/iSample/iLast/oReady (sample input handshake),           |
// |            oValid/oLag/oACF/oDone (one lag per cycle output stream).       |
// | Options  : ACF_ROUND_EN - round-to-nearest-even mantissa instead of        |
// |            truncation toward zero.                                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module autocorrelation_calculator #(
   parameter int ORDER      = 12,
   parameter int SAMPLE_W   = 16,
   parameter int BLOCK_SIZE = 4096
) (
   input  logic                          iClock,
   input  logic                          iReset,
   input  logic                          iEnable,
   input  logic                          iValid,
   input  logic signed [SAMPLE_W-1:0]    iSample,
   input  logic                          iLast,
   output logic                          oReady,
   output logic                          oValid,
   output logic [$clog2(ORDER+1)-1:0]    oLag,
   output logic [31:0]                   oACF,
   output logic                          oDone
);
   localparam int ACC_W  = 2*SAMPLE_W + $clog2(BLOCK_SIZE);
   localparam int PROD_W = 2*SAMPLE_W;
   localparam int LAG_W  = $clog2(ORDER+1);
   // Normalisation window must hold leading one, 23 mantissa bits, guard and sticky.
   localparam int NORM_W = (ACC_W < 26) ? 26 : ACC_W;
   localparam logic [LAG_W-1:0] LAG_LAST = LAG_W'(ORDER);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FLUSH = 2'd1,
      ST_EMIT  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [LAG_W-1:0]           lag_cnt_q, lag_cnt_d;
   logic                       valid_q, valid_d;
   logic                       done_q, done_d;
   logic [LAG_W-1:0]           lag_q, lag_d;
   logic [31:0]                acf_q, acf_d;
   logic                       prod_vld_q, prod_vld_d;
   logic signed [PROD_W-1:0]   prod_q [0:ORDER];
   logic signed [PROD_W-1:0]   prod_d [0:ORDER];
   logic signed [SAMPLE_W-1:0] dly_q  [0:ORDER-1];
   logic signed [SAMPLE_W-1:0] dly_d  [0:ORDER-1];
   logic signed [ACC_W-1:0]    acc_q  [0:ORDER];
   logic signed [ACC_W-1:0]    acc_d  [0:ORDER];

   logic                       accept;
   logic signed [ACC_W-1:0]    cvt_in;
   logic [NORM_W-1:0]          cvt_mag;
   logic [NORM_W-1:0]          cvt_norm;
   logic [7:0]                 cvt_pos;
   logic [22:0]                cvt_mant;
   logic                       cvt_guard;
   logic                       cvt_sticky;
   logic [30:0]                cvt_body;
   logic [31:0]                cvt_word;
   logic                       unused_cvt_bits;

   function automatic logic signed [PROD_W-1:0] mul(input logic signed [SAMPLE_W-1:0] a,
                                                    input logic signed [SAMPLE_W-1:0] b);
      return PROD_W'(a) * PROD_W'(b);
   endfunction

   assign oReady = (state_q == ST_ACCUM);
   assign oValid = valid_q;
   assign oLag   = lag_q;
   assign oACF   = acf_q;
   assign oDone  = done_q;

   // Fixed-point to single-precision conversion of the lag being drained.
   assign cvt_in = acc_q[lag_cnt_q];

   always_comb begin
      cvt_mag = '0;
      cvt_mag[ACC_W-1:0] = cvt_in[ACC_W-1] ? -cvt_in : cvt_in;
      cvt_pos = '0;
      for (int i = 0; i < NORM_W; i++) begin
         if (cvt_mag[i]) cvt_pos = 8'(i);
      end
      // Shift so the leading one sits at the top of the window.
      cvt_norm   = cvt_mag << (8'(NORM_W-1) - cvt_pos);
      cvt_mant   = cvt_norm[NORM_W-2 -: 23];
      cvt_guard  = cvt_norm[NORM_W-25];
      cvt_sticky = |cvt_norm[NORM_W-26:0];
      cvt_body   = {8'd127 + cvt_pos, cvt_mant};
`ifdef ACF_ROUND_EN
      // A mantissa carry ripples into the exponent field naturally.
      if (cvt_guard && (cvt_sticky || cvt_mant[0])) cvt_body = cvt_body + 31'd1;
`else
`endif
      cvt_word = (cvt_mag == '0) ? 32'd0 : {cvt_in[ACC_W-1], cvt_body};
   end

   assign unused_cvt_bits = ^{cvt_norm[NORM_W-1], cvt_guard, cvt_sticky};

   always_comb begin
      state_d    = state_q;
      lag_cnt_d  = lag_cnt_q;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      lag_d      = lag_q;
      acf_d      = acf_q;
      prod_vld_d = 1'b0;
      prod_d     = prod_q;
      dly_d      = dly_q;
      acc_d      = acc_q;
      accept     = iValid && (state_q == ST_ACCUM);

      // Stage 2: fold last cycle's products into the accumulators.
      if (prod_vld_q) begin
         for (int k = 0; k <= ORDER; k++) acc_d[k] = acc_q[k] + ACC_W'(prod_q[k]);
      end

      // Stage 1: products of the new sample against itself and its history.
      if (accept) begin
         prod_vld_d = 1'b1;
         prod_d[0]  = mul(iSample, iSample);
         for (int k = 1; k <= ORDER; k++) prod_d[k] = mul(iSample, dly_q[k-1]);
         dly_d[0] = iSample;
         for (int i = 1; i < ORDER; i++) dly_d[i] = dly_q[i-1];
         if (iLast) state_d = ST_FLUSH;
      end

      case (state_q)
         ST_FLUSH: begin
            state_d   = ST_EMIT;
            lag_cnt_d = '0;
         end
         ST_EMIT: begin
            valid_d = 1'b1;
            lag_d   = lag_cnt_q;
            acf_d   = cvt_word;
            if (lag_cnt_q == LAG_LAST) begin
               done_d  = 1'b1;
               state_d = ST_CLEAR;
               for (int k = 0; k <= ORDER; k++) acc_d[k] = '0;
               for (int i = 0; i < ORDER; i++) dly_d[i] = '0;
            end else begin
               lag_cnt_d = lag_cnt_q + 1'b1;
            end
         end
         // Holds oReady low for the cycle carrying oDone.
         ST_CLEAR: state_d = ST_ACCUM;
         default: ;
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q    <= ST_ACCUM;
         lag_cnt_q  <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         lag_q      <= '0;
         acf_q      <= '0;
         prod_vld_q <= 1'b0;
         for (int k = 0; k <= ORDER; k++) begin
            prod_q[k] <= '0;
            acc_q[k]  <= '0;
         end
         for (int i = 0; i < ORDER; i++) dly_q[i] <= '0;
      end else if (iEnable) begin
         state_q    <= state_d;
         lag_cnt_q  <= lag_cnt_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         lag_q      <= lag_d;
         acf_q      <= acf_d;
         prod_vld_q <= prod_vld_d;
         for (int k = 0; k <= ORDER; k++) begin
            prod_q[k] <= prod_d[k];
            acc_q[k]  <= acc_d[k];
         end
         for (int i = 0; i < ORDER; i++) dly_q[i] <= dly_d[i];
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_autocorrelation_calculator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_autocorrelation_calculator                                   |
// | Purpose  : Self-checking bench for autocorrelation_calculator: directed    |
// |            blocks with literal results plus random blocks against a       |
// |            behavioural model. Honors ACF_ROUND_EN like the design.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_autocorrelation_calculator;
   localparam int ORDER = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              iEnable = 1'b1;
   logic              iValid = 1'b0;
   logic signed [15:0] iSample = '0;
   logic              iLast = 1'b0;
   logic              oReady, oValid, oDone;
   logic [3:0]        oLag;
   logic [31:0]       oACF;

   int checks = 0;
   int failures = 0;
   bit rand_en = 1'b0;

   autocorrelation_calculator #(.ORDER(ORDER), .SAMPLE_W(16), .BLOCK_SIZE(4096)) dut (
      .iClock(clk), .iReset(rst), .iEnable(iEnable), .iValid(iValid), .iSample(iSample),
      .iLast(iLast), .oReady(oReady), .oValid(oValid), .oLag(oLag), .oACF(oACF), .oDone(oDone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference integer -> IEEE-754 single conversion from first principles.
   function automatic logic [31:0] to_float(input longint v);
      longint unsigned m, mant, rem, half;
      int p;
      int e;
      if (v == 0) return 32'd0;
      m = (v < 0) ? longint'(-v) : v;
      p = 63;
      while (((m >> p) & 64'd1) == 64'd0) p--;
      if (p <= 23) begin
         mant = m << (23 - p);
      end else begin
         mant = m >> (p - 23);
         rem  = m - (mant << (p - 23));
         half = 64'd1 << (p - 24);
`ifdef ACF_ROUND_EN
         if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
`else
         if (rem > half && half == 64'd0) mant = mant + 64'd1;
`endif
      end
      e = 127 + p;
      if (mant >= (64'd1 << 24)) begin
         mant = mant >> 1;
         e++;
      end
      return {v < 0, 8'(e), 23'(mant)};
   endfunction

   // ---------------- behavioural model ----------------
   int          blk[$];
   logic [31:0] exp_acf [0:ORDER];
   int          busy = 0;       // cycles (enabled) until the block is ready again
   longint      cyc = 0;
   longint      last_t = 0;
   longint      done_cyc = -1;
   longint      s;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         blk.delete();
         busy = 0;
      end else begin
         if (iEnable) begin
            if (busy == 0 && iValid) begin
               blk.push_back(int'(iSample));
               if (iLast) begin
                  for (int k = 0; k <= ORDER; k++) begin
                     s = 0;
                     for (int n = k; n < blk.size(); n++)
                        s += longint'(blk[n]) * longint'(blk[n-k]);
                     exp_acf[k] = to_float(s);
                  end
                  blk.delete();
                  busy = ORDER + 3;
                  last_t = cyc;
               end
            end else if (busy > 0) begin
               busy--;
            end
         end
         cyc++;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [31:0] cap_acf [0:ORDER];
   int          vcount = 0;
   bit          exp_valid;
   int          exp_lag;

   always @(negedge clk) begin
      exp_valid = (busy >= 1) && (busy <= ORDER + 1);
      exp_lag   = ORDER + 1 - busy;
      chk("ready", 32'(oReady), 32'(busy == 0));
      chk("valid", 32'(oValid), 32'(exp_valid));
      if (exp_valid && oValid) begin
         chk("lag",  32'(oLag),  32'(exp_lag));
         chk("acf",  oACF,       exp_acf[exp_lag]);
         chk("done", 32'(oDone), 32'(busy == 1));
      end else begin
         chk("done_idle", 32'(oDone), 32'd0);
      end
      if (oValid && oLag <= 4'(ORDER)) begin
         cap_acf[oLag] = oACF;
         vcount++;
         if (oDone) done_cyc = cyc;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
      if (rand_en) iEnable = ($urandom % 8) != 0;
   endtask

   task automatic send(input int smp, input bit last);
      int n = 0;
      iValid = 1'b1;
      iSample = 16'(smp);
      iLast = last;
      while (!(oReady && iEnable)) begin
         step();
         n++;
         if (n > 300) begin
            chk("send_timeout", 32'd1, 32'd0);
            break;
         end
      end
      step();
      iValid = 1'b0;
      iLast = 1'b0;
      iSample = 16'($urandom);
   endtask

   // Drains a block, offering junk samples while not ready; they must be dropped.
   task automatic wait_done();
      int n = 0;
      while (!oReady) begin
         step();
         iValid  = !oReady && ($urandom % 2 == 1);
         iSample = 16'($urandom);
         iLast   = ($urandom % 2 == 1);
         n++;
         if (n > 300) begin
            chk("drain_timeout", 32'd1, 32'd0);
            break;
         end
      end
      iValid = 1'b0;
      iLast = 1'b0;
   endtask

   task automatic clear_cap();
      for (int k = 0; k <= ORDER; k++) cap_acf[k] = 32'hDEADBEEF;
      vcount = 0;
      done_cyc = -1;
   endtask

   initial begin
      int len;
      #1 rst = 1'b1;
      #20;
      chk("rst_ready", 32'(oReady), 32'd1);
      chk("rst_valid", 32'(oValid), 32'd0);
      chk("rst_lag",   32'(oLag),   32'd0);
      chk("rst_acf",   oACF,        32'd0);
      chk("rst_done",  32'(oDone),  32'd0);
      step();
      rst = 1'b0;
      step();

      // Model pins
      chk("model_m3",  to_float(-3),          32'hC0400000);
      chk("model_2e30", to_float(64'sd1 << 30), 32'h4E800000);

      // Block 1,1,1,1
      clear_cap();
      for (int i = 0; i < 4; i++) send(1, i == 3);
      wait_done();
      chk("b1_lag0", cap_acf[0], 32'h40800000);
      chk("b1_lag1", cap_acf[1], 32'h40400000);
      chk("b1_lag2", cap_acf[2], 32'h40000000);
      chk("b1_lag3", cap_acf[3], 32'h3F800000);
      chk("b1_lag4", cap_acf[4], 32'h00000000);
      for (int k = 5; k <= ORDER; k++) chk("b1_hi", cap_acf[k], 32'h00000000);
      chk("b1_done_t", 32'(done_cyc - last_t), 32'd15);

      // Block 1,-1,1,-1
      clear_cap();
      for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 1 : -1, i == 3);
      wait_done();
      chk("b2_lag0", cap_acf[0], 32'h40800000);
      chk("b2_lag1", cap_acf[1], 32'hC0400000);
      chk("b2_lag2", cap_acf[2], 32'h40000000);
      chk("b2_lag3", cap_acf[3], 32'hBF800000);

      // Block 4096,1,1,1 exercises mantissa rounding
      clear_cap();
      send(4096, 1'b0); send(1, 1'b0); send(1, 1'b0); send(1, 1'b1);
      wait_done();
`ifdef ACF_ROUND_EN
      chk("b3_lag0", cap_acf[0], 32'h4B800002);
`else
      chk("b3_lag0", cap_acf[0], 32'h4B800001);
`endif
      chk("b3_lag1", cap_acf[1], 32'h45801000);

      // Single sample, then immediately 2,2
      clear_cap();
      send(-32768, 1'b1);
      wait_done();
      chk("b4_lag0", cap_acf[0], 32'h4E800000);
      chk("b4_lag1", cap_acf[1], 32'h00000000);
      chk("b4_lagN", cap_acf[ORDER], 32'h00000000);
      clear_cap();
      send(2, 1'b0); send(2, 1'b1);
      wait_done();
      chk("b5_lag0", cap_acf[0], 32'h41000000);
      chk("b5_lag1", cap_acf[1], 32'h40800000);

      // Reset mid-EMIT
      send(7, 1'b0); send(-5, 1'b1);
      for (int i = 0; i < 6; i++) step();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(oValid), 32'd0);
      chk("mid_rst_ready", 32'(oReady), 32'd1);
      step();
      rst = 1'b0;
      clear_cap();
      send(3, 1'b1);
      wait_done();
      chk("b6_lag0", cap_acf[0], 32'h41100000);

      // Enable held low for two cycles during EMIT
      clear_cap();
      send(100, 1'b0); send(-200, 1'b0); send(300, 1'b1);
      for (int i = 0; i < 4; i++) step();
      iEnable = 1'b0;
      step(); step();
      iEnable = 1'b1;
      wait_done();
      chk("hold_vcount", 32'(vcount), 32'(ORDER + 1 + 2));
      chk("hold_lagN", cap_acf[ORDER], 32'h00000000);

      // Random blocks with random enable drops and gaps
      rand_en = 1'b1;
      for (int b = 0; b < 25; b++) begin
         len = 1 + int'($urandom % 40);
         for (int i = 0; i < len; i++) begin
            send(int'($urandom), i == len - 1);
            if ($urandom % 4 == 0) step();
         end
         wait_done();
      end
      rand_en = 1'b0;
      iEnable = 1'b1;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
